// File: rtl/ogfx_lt24_refresh.sv
// LT24 refresh engine: fetches pixels from the backend and writes them over a 16-bit 8080 bus.
// Build option OGFX_LT24_CMD_EN prefixes every frame with the 0x002C memory-write command.
module ogfx_lt24_refresh #(
    parameter int SPIX_W = 17
) (
    input  logic              mclk,
    input  logic              puc_rst_n,
    input  logic [SPIX_W-1:0] display_size_i,
    input  logic [2:0]        cfg_wr_div_i,
    input  logic              refresh_start_i,
    input  logic              refresh_abort_i,
    input  logic [15:0]       refresh_data_i,
    input  logic              refresh_data_ready_i,
    output logic              refresh_data_request_o,
    output logic              refresh_active_o,
    output logic              frame_done_o,
    output logic              lt24_cs_n_o,
    output logic              lt24_rs_o,
    output logic              lt24_wr_n_o,
    output logic [15:0]       lt24_d_o,
    output logic              lt24_d_en_o
);
    typedef enum logic [2:0] {IDLE, CMD_LO, CMD_HI, WAIT, DAT_LO, DAT_HI, DONE} state_t;

    state_t            state, n_state;
    logic [SPIX_W-1:0] req_cnt, n_req_cnt, wr_cnt, n_wr_cnt;
    logic [2:0]        ph_cnt, n_ph_cnt;
    logic [15:0]       buf_data, n_buf_data, d, n_d;
    logic              buf_full, n_buf_full, pending, n_pending;
    logic              active, n_active, done, n_done;
    logic              cs_n, n_cs_n, rs, n_rs, wr_n, n_wr_n, d_en, n_d_en;
    logic              request, rdy_ok, avail, phase_end, xfer;
    logic [15:0]       avail_data;

    assign request    = active && !buf_full && !pending && (req_cnt != '0);
    assign rdy_ok     = refresh_data_ready_i && active && !buf_full;
    // A word arriving while the strobe FSM is ready to send bypasses the buffer.
    assign avail      = buf_full || rdy_ok;
    assign avail_data = buf_full ? buf_data : refresh_data_i;
    assign phase_end  = (ph_cnt == cfg_wr_div_i);

    always_comb begin
        n_state    = state;
        n_req_cnt  = req_cnt;
        n_wr_cnt   = wr_cnt;
        n_ph_cnt   = ph_cnt;
        n_buf_data = buf_data;
        n_buf_full = buf_full;
        n_pending  = pending;
        n_active   = active;
        n_done     = 1'b0;
        n_cs_n     = cs_n;
        n_rs       = rs;
        n_wr_n     = wr_n;
        n_d        = d;
        n_d_en     = d_en;
        xfer       = 1'b0;

        if (request) begin
            n_req_cnt = req_cnt - SPIX_W'(1);
            n_pending = 1'b1;
        end
        if (refresh_data_ready_i) n_pending = 1'b0;
        if (rdy_ok) begin
            n_buf_full = 1'b1;
            n_buf_data = refresh_data_i;
        end

        case (state)
            IDLE: begin
                if (refresh_start_i && display_size_i != '0) begin
                    n_req_cnt = display_size_i;
                    n_wr_cnt  = display_size_i;
                    n_active  = 1'b1;
                    n_cs_n    = 1'b0;
                    n_d_en    = 1'b1;
                    n_ph_cnt  = '0;
`ifdef OGFX_LT24_CMD_EN
                    n_state   = CMD_LO;
                    n_wr_n    = 1'b0;
                    n_rs      = 1'b0;
                    n_d       = 16'h002C;
`else
                    n_state   = WAIT;
`endif
                end
            end
`ifdef OGFX_LT24_CMD_EN
            CMD_LO: begin
                if (phase_end) begin
                    n_state  = CMD_HI;
                    n_wr_n   = 1'b1;
                    n_ph_cnt = '0;
                end else n_ph_cnt = ph_cnt + 3'd1;
            end
            CMD_HI: begin
                if (phase_end) begin
                    n_ph_cnt = '0;
                    if (avail) xfer = 1'b1;
                    else       n_state = WAIT;
                end else n_ph_cnt = ph_cnt + 3'd1;
            end
`endif
            WAIT: if (avail) xfer = 1'b1;
            DAT_LO: begin
                if (phase_end) begin
                    n_state  = DAT_HI;
                    n_wr_n   = 1'b1;
                    n_ph_cnt = '0;
                end else n_ph_cnt = ph_cnt + 3'd1;
            end
            DAT_HI: begin
                if (phase_end) begin
                    n_ph_cnt = '0;
                    n_wr_cnt = (wr_cnt != '0) ? wr_cnt - SPIX_W'(1) : '0;
                    if (wr_cnt <= SPIX_W'(1)) begin
                        n_state  = DONE;
                        n_done   = 1'b1;
                        n_cs_n   = 1'b1;
                        n_d_en   = 1'b0;
                        n_active = 1'b0;
                    end else if (avail) xfer = 1'b1;
                    else n_state = WAIT;
                end else n_ph_cnt = ph_cnt + 3'd1;
            end
            DONE:    n_state = IDLE;
            default: n_state = IDLE;
        endcase

        if (xfer) begin
            n_state    = DAT_LO;
            n_wr_n     = 1'b0;
            n_rs       = 1'b1;
            n_d        = avail_data;
            n_buf_full = 1'b0;
            n_ph_cnt   = '0;
        end

        if (refresh_abort_i) begin
            n_state    = IDLE;
            n_req_cnt  = '0;
            n_wr_cnt   = '0;
            n_ph_cnt   = '0;
            n_buf_data = '0;
            n_buf_full = 1'b0;
            n_pending  = 1'b0;
            n_active   = 1'b0;
            n_done     = 1'b0;
            n_cs_n     = 1'b1;
            n_rs       = 1'b1;
            n_wr_n     = 1'b1;
            n_d        = '0;
            n_d_en     = 1'b0;
        end
    end

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            state    <= IDLE;
            req_cnt  <= '0;
            wr_cnt   <= '0;
            ph_cnt   <= '0;
            buf_data <= '0;
            buf_full <= 1'b0;
            pending  <= 1'b0;
            active   <= 1'b0;
            done     <= 1'b0;
            cs_n     <= 1'b1;
            rs       <= 1'b1;
            wr_n     <= 1'b1;
            d        <= '0;
            d_en     <= 1'b0;
        end else begin
            state    <= n_state;
            req_cnt  <= n_req_cnt;
            wr_cnt   <= n_wr_cnt;
            ph_cnt   <= n_ph_cnt;
            buf_data <= n_buf_data;
            buf_full <= n_buf_full;
            pending  <= n_pending;
            active   <= n_active;
            done     <= n_done;
            cs_n     <= n_cs_n;
            rs       <= n_rs;
            wr_n     <= n_wr_n;
            d        <= n_d;
            d_en     <= n_d_en;
        end
    end

    assign refresh_data_request_o = request;
    assign refresh_active_o       = active;
    assign frame_done_o           = done;
    assign lt24_cs_n_o            = cs_n;
    assign lt24_rs_o              = rs;
    assign lt24_wr_n_o            = wr_n;
    assign lt24_d_o               = d;
    assign lt24_d_en_o            = d_en;
endmodule
